bullcow_display: RTL and testbench

- Output-side companion to the Bulls & Cows game FSM; it reads what the game produces and presents it on the board's 8-digit multiplexed 7-segment display.
- Inputs: game phase, current switch entry, last bulls/cows result, entry-rejected pulse, player points.
- Outputs: time-multiplexed active-low anode/cathode drive; the blink/flash timers are owned here.

---
 rtl/bullcow_pkg.sv | 37 +++
 rtl/bullcow_display_glyph_to_seg.sv | 26 ++
 rtl/bullcow_display.sv | 164 ++++++++++++++++
 tb/tb_bullcow_display.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bullcow_pkg.sv
// Shared types and segment constants for the Bulls & Cows game and its display.
package bullcow_pkg;

    typedef enum logic [2:0] {
        J1_SETUP = 3'b000,
        J2_SETUP = 3'b001,
        J1_GUESS = 3'b010,
        J2_GUESS = 3'b011,
        END_GAME = 3'b111
    } state_t;

    typedef enum logic [4:0] {
        HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7,
        HEX8, HEX9, HEXA, HEXB, HEXC, HEXD, HEXE, HEXF,
        G_J, G_P, G_B, G_C, G_DASH, G_BLANK
    } glyph_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] SEG_J     = 7'b1100001;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b0100111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex glyphs occupy codes 0..15, so a nibble maps directly.
    function automatic glyph_t hex_glyph(input logic [3:0] v);
        return glyph_t'({1'b0, v});
    endfunction

endpackage

// File: rtl/bullcow_display_glyph_to_seg.sv
// Combinational glyph code to active-low 7-segment pattern.
module glyph_to_seg
    import bullcow_pkg::*;
(
    input  logic [4:0] i_glyph,
    output logic [6:0] o_seg
);

    // Hex codes index the table directly; the rest are named symbols.
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_glyph[4]) begin
            o_seg = SEG_HEX[i_glyph[3:0]];
        end else begin
            case (i_glyph)
                G_J:     o_seg = SEG_J;
                G_P:     o_seg = SEG_P;
                G_B:     o_seg = SEG_B;
                G_C:     o_seg = SEG_C;
                G_DASH:  o_seg = SEG_DASH;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bullcow_display.sv
// 8-digit multiplexed display driver for the Bulls & Cows game.
module bullcow_display
    import bullcow_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [2:0]      phase,
    input  logic [3:0][3:0] entry,
    input  logic [2:0]      bulls,
    input  logic [2:0]      cows,
    input  logic            result_valid,
    input  logic            invalid,
    input  logic [1:0][7:0] points,
    input  logic            winner,
    output logic [7:0]      an,
    output logic [7:0]      dec_cat
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [TW-1:0] r_tick_cnt;
    logic [2:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;
    logic [2:0]    r_err_half;
    logic [BW-1:0] r_err_cnt;
    logic          r_res_held;
    logic [2:0]    r_res_b;
    logic [2:0]    r_res_c;
    logic [2:0]    r_phase_q;

    logic          w_tick;
    logic          w_entry_blank;
    logic          w_dp;
    glyph_t        w_dig [8];
    glyph_t        w_sel;
    logic [6:0]    w_seg;

    assign w_tick        = (r_tick_cnt == TICK_LAST);
    assign w_entry_blank = (r_err_half != 3'd0) && !r_err_half[0];

    // Digit-slot timer, scan index and free-running blink phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 3'd1;
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink_ph  <= ~r_blink_ph;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // Latch the last scored guess; a setup phase forgets it unless a result lands that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_res_held <= 1'b0;
            r_res_b    <= '0;
            r_res_c    <= '0;
        end else if (result_valid) begin
            r_res_held <= 1'b1;
            r_res_b    <= bulls;
            r_res_c    <= cows;
        end else if (phase[2:1] == 2'b00) begin
            r_res_held <= 1'b0;
        end
    end

    // Rejected-entry flash: four half-periods counted down, restarted by invalid, cancelled by a phase change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_half <= '0;
            r_err_cnt  <= '0;
            r_phase_q  <= '0;
        end else begin
            r_phase_q <= phase;
            if (invalid) begin
                r_err_half <= 3'd4;
                r_err_cnt  <= '0;
            end else if (phase != r_phase_q) begin
                r_err_half <= '0;
                r_err_cnt  <= '0;
            end else if (w_tick && (r_err_half != 3'd0)) begin
                if (r_err_cnt == BLINK_LAST) begin
                    r_err_cnt  <= '0;
                    r_err_half <= r_err_half - 3'd1;
                end else begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    // Per-phase digit contents and the glyph for the digit currently being scanned.
    always_comb begin
        w_dig = '{default: G_DASH};
        w_dp  = 1'b1;
        case (phase)
            J1_SETUP, J2_SETUP: begin
                w_dig[7] = G_J;
                w_dig[6] = phase[0] ? HEX2 : HEX1;
                w_dig[5] = G_BLANK;
                w_dig[4] = G_DASH;
            end
            J1_GUESS, J2_GUESS: begin
                w_dig[7] = G_J;
                w_dig[6] = phase[0] ? HEX2 : HEX1;
                w_dig[5] = r_res_held ? hex_glyph({1'b0, r_res_b}) : G_DASH;
                w_dig[4] = r_res_held ? hex_glyph({1'b0, r_res_c}) : G_DASH;
                w_dp     = (r_idx != 3'd6);
            end
            END_GAME: begin
                w_dig[7] = G_P;
                w_dig[6] = HEX1;
                w_dig[5] = (r_blink_ph && !winner) ? G_BLANK : hex_glyph(points[0][7:4]);
                w_dig[4] = (r_blink_ph && !winner) ? G_BLANK : hex_glyph(points[0][3:0]);
                w_dig[3] = G_P;
                w_dig[2] = HEX2;
                w_dig[1] = (r_blink_ph && winner) ? G_BLANK : hex_glyph(points[1][7:4]);
                w_dig[0] = (r_blink_ph && winner) ? G_BLANK : hex_glyph(points[1][3:0]);
            end
            default: ;
        endcase
        if (phase[2] == 1'b0) begin
            w_dig[3] = w_entry_blank ? G_BLANK : hex_glyph(entry[3]);
            w_dig[2] = w_entry_blank ? G_BLANK : hex_glyph(entry[2]);
            w_dig[1] = w_entry_blank ? G_BLANK : hex_glyph(entry[1]);
            w_dig[0] = w_entry_blank ? G_BLANK : hex_glyph(entry[0]);
        end
        w_sel = w_dig[r_idx];
    end

    glyph_to_seg u_glyph_to_seg (
        .i_glyph (w_sel),
        .o_seg   (w_seg)
    );

    // Registered drive: one anode low at the scan index, cathodes for that digit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an      <= 8'hFF;
            dec_cat <= 8'hFF;
        end else begin
            an      <= ~(8'b1 << r_idx);
            dec_cat <= {w_dp, w_seg};
        end
    end

endmodule

// File: tb/tb_bullcow_display.sv
// Self-checking bench for bullcow_display with a behavioural display model.
module tb_bullcow_display;

    localparam int RD = 4;
    localparam int BT = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [2:0]      phase = 3'b000;
    logic [3:0][3:0] entry = '0;
    logic [2:0]      bulls = '0;
    logic [2:0]      cows  = '0;
    logic            result_valid = 1'b0;
    logic            invalid = 1'b0;
    logic [1:0][7:0] points = '0;
    logic            winner = 1'b0;
    logic [7:0]      an;
    logic [7:0]      dec_cat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit m_held = 1'b0;
    int m_rb = 0;
    int m_rc = 0;
    int m_inv = -1;

    bullcow_display #(
        .REFRESH_DIV (RD),
        .BLINK_TICKS (BT)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .phase        (phase),
        .entry        (entry),
        .bulls        (bulls),
        .cows         (cows),
        .result_valid (result_valid),
        .invalid      (invalid),
        .points       (points),
        .winner       (winner),
        .an           (an),
        .dec_cat      (dec_cat)
    );

    always #5 clock = ~clock;

    // Clock edges since reset release.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic byte hexch(input int v);
        return (v < 10) ? byte'(48 + v) : byte'(55 + v);
    endfunction

    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "0": return 7'b1000000;  "1": return 7'b1111001;
            "2": return 7'b0100100;  "3": return 7'b0110000;
            "4": return 7'b0011001;  "5": return 7'b0010010;
            "6": return 7'b0000010;  "7": return 7'b1111000;
            "8": return 7'b0000000;  "9": return 7'b0010000;
            "A": return 7'b0001000;  "B": return 7'b0000011;
            "C": return 7'b1000110;  "D": return 7'b0100001;
            "E": return 7'b0000110;  "F": return 7'b0001110;
            "J": return 7'b1100001;  "P": return 7'b0001100;
            "-": return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_now();
        int t, idx, bph, k, half;
        bit eblank, dp;
        byte s [8];
        logic [7:0] ea, ed;
        if (reset) begin
            ea = 8'hFF;
            ed = 8'hFF;
        end else begin
            t   = (cyc - 1) / RD;
            idx = t % 8;
            bph = (t / BT) % 2;
            eblank = 1'b0;
            if (m_inv >= 0) begin
                k = t - m_inv / RD;
                half = 4 - k / BT;
                if (half < 0) half = 0;
                eblank = (half > 0) && (half % 2 == 0);
            end
            dp = 1'b1;
            for (int i = 0; i < 8; i++) s[i] = "-";
            case (phase)
                3'd0, 3'd1: begin
                    s[7] = "J"; s[6] = phase[0] ? "2" : "1"; s[5] = " "; s[4] = "-";
                end
                3'd2, 3'd3: begin
                    s[7] = "J"; s[6] = phase[0] ? "2" : "1";
                    s[5] = m_held ? hexch(m_rb) : "-";
                    s[4] = m_held ? hexch(m_rc) : "-";
                    if (idx == 6) dp = 1'b0;
                end
                3'd7: begin
                    s[7] = "P"; s[6] = "1"; s[3] = "P"; s[2] = "2";
                    s[5] = hexch(int'(points[0][7:4])); s[4] = hexch(int'(points[0][3:0]));
                    s[1] = hexch(int'(points[1][7:4])); s[0] = hexch(int'(points[1][3:0]));
                    if (bph == 1) begin
                        if (winner) begin s[1] = " "; s[0] = " "; end
                        else        begin s[5] = " "; s[4] = " "; end
                    end
                end
                default: ;
            endcase
            if (phase < 3'd4) begin
                for (int i = 0; i < 4; i++) s[i] = eblank ? " " : hexch(int'(entry[i]));
            end
            ea = ~(8'b1 << idx);
            ed = {dp, seg_of(s[idx])};
        end
        total++;
        assert (an === ea) else begin
            bad++;
            $error("FAIL an cyc=%0d got=%h exp=%h", cyc, an, ea);
        end
        total++;
        assert (dec_cat === ed) else begin
            bad++;
            $error("FAIL dec_cat cyc=%0d phase=%0d got=%b exp=%b", cyc, phase, dec_cat, ed);
        end
    endtask

    task automatic run(input int n, input bit chk);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (chk) check_now();
        end
    endtask

    task automatic set_phase(input logic [2:0] p);
        if (p != phase) m_inv = -1;
        if (p[2:1] == 2'b00) m_held = 1'b0;
        phase = p;
        run(1, 1'b0);
    endtask

    task automatic pulse_rv(input int b, input int c);
        bulls = 3'(b);
        cows  = 3'(c);
        result_valid = 1'b1;
        run(1, 1'b0);
        result_valid = 1'b0;
        m_held = 1'b1;
        m_rb = b;
        m_rc = c;
    endtask

    task automatic pulse_inv();
        invalid = 1'b1;
        m_inv = cyc + 1;
        run(1, 1'b0);
        invalid = 1'b0;
    endtask

    initial begin
        entry[3] = 4'd1; entry[2] = 4'd2; entry[1] = 4'd3; entry[0] = 4'd4;
        // Held in reset: blank, no scan.
        run(5, 1'b1);
        reset = 1'b0;
        run(40, 1'b1);

        // Setup phases with random entries.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) entry[i] = 4'($urandom_range(15, 0));
            set_phase(3'(r % 2));
            run(36, 1'b1);
        end

        // Guess phases and result latch.
        set_phase(3'd2);
        run(16, 1'b1);
        pulse_rv(2, 1);
        run(36, 1'b1);
        set_phase(3'd3);
        run(36, 1'b1);
        set_phase(3'd0);
        run(8, 1'b1);
        set_phase(3'd2);
        run(36, 1'b1);
        for (int r = 0; r < 4; r++) begin
            pulse_rv(int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
            for (int i = 0; i < 4; i++) entry[i] = 4'($urandom_range(15, 0));
            set_phase(3'(2 + (r % 2)));
            run(34, 1'b1);
        end

        // Error flash, restart mid-flash, cancel by phase change, flash in guess.
        set_phase(3'd1);
        pulse_inv();
        run(48, 1'b1);
        pulse_inv();
        for (int g = 0; g < 100; g++) begin
            run(1, 1'b1);
            if ((cyc - 1) / RD - m_inv / RD >= 3) break;
        end
        pulse_inv();
        run(48, 1'b1);
        pulse_inv();
        run(6, 1'b1);
        set_phase(3'd2);
        run(16, 1'b1);
        pulse_inv();
        run(40, 1'b1);

        // End of game with blinking winner.
        points[0] = 8'h03;
        points[1] = 8'h1A;
        winner = 1'b1;
        set_phase(3'd7);
        run(80, 1'b1);
        for (int r = 0; r < 2; r++) begin
            points[0] = 8'($urandom_range(255, 0));
            points[1] = 8'($urandom_range(255, 0));
            winner = r[0] ? 1'b1 : 1'b0;
            winner = ~winner;
            run(1, 1'b0);
            run(72, 1'b1);
        end

        // Unused phase codes.
        set_phase(3'd5);
        run(36, 1'b1);
        set_phase(3'd4);
        run(36, 1'b1);
        set_phase(3'd6);
        run(36, 1'b1);

        // Asynchronous reset in the middle of a slot.
        set_phase(3'd2);
        pulse_rv(3, 4);
        run(13, 1'b1);
        #3 reset = 1'b1;
        m_held = 1'b0;
        m_inv = -1;
        #1 check_now();
        run(3, 1'b1);
        reset = 1'b0;
        run(40, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
